jcs_mem_console: RTL and testbench



---
 rtl/jcs_pkg.sv | 30 +++
 rtl/jcs_sp_ram.sv | 22 ++
 rtl/jcs_mem_console.sv | 163 ++++++++++++++++
 tb/tb_jcs_mem_console.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/jcs_pkg.sv
// Shared types and constants for the memory console.
// Mode numbering, fill FSM encoding and 7-segment words.
package jcs_pkg;

  typedef enum logic [2:0] {
    MEM  = 3'd1,
    REG  = 3'd2,
    RAM  = 3'd3,
    SCAN = 3'd4,
    FILL = 3'd5
  } mode_t;

  localparam mode_t FIRST = MEM;
  localparam mode_t LAST  = FILL;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fill_t;

  localparam logic [31:0] W_MEM  = " mem";
  localparam logic [31:0] W_REG  = " reg";
  localparam logic [31:0] W_RAM  = " ram";
  localparam logic [31:0] W_SCAN = "scan";
  localparam logic [31:0] W_PAUS = "paus";
  localparam logic [31:0] W_BSY  = " bsy";
  localparam logic [31:0] W_FILL = "fill";

endpackage

// File: rtl/jcs_sp_ram.sv
// Single write port, read-first synchronous read port.
// Contents are deliberately not reset.
module jcs_sp_ram #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/jcs_mem_console.sv
// Mode-stepped memory console: bit, register, RAM,
// auto-scan read-out and a busy-flagged fill engine.
module jcs_mem_console
  import jcs_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int AW         = 4,
  parameter int SCAN_TICKS = 50000000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [15:0] SW,
  input  logic        UP,
  input  logic        DOWN,
  input  logic        SET,
  input  logic        ENA,
  input  logic        ACT,
  output logic [15:0] LED,
  output logic [31:0] WORD,
  output logic        BUSY
);

  localparam int DEPTH = 2**AW;
  localparam int TW    = $clog2(SCAN_TICKS);

  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic             w_unused;

  assign w_addr   = SW[8+AW-1:8];
  assign w_data   = SW[WIDTH-1:0];
  assign w_unused = ^SW;

  mode_t            r_mode, w_mode_nxt;
  fill_t            r_fst, w_fst_nxt;
  logic             r_mem_bit;
  logic [WIDTH-1:0] r_reg;
  logic [AW-1:0]    r_scan_addr;
  logic [TW-1:0]    r_tick;
  logic             r_run;
  logic [WIDTH-1:0] r_base;
  logic [AW-1:0]    r_i;

  logic             w_scan_entry;
  logic             w_fill_start;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [AW-1:0]    w_raddr;
  logic [WIDTH-1:0] w_rdata;

  assign BUSY = (r_fst == RUN);

  // UP has priority even when it is clamped at the first mode
  always_comb begin
    w_mode_nxt = r_mode;
    if (!BUSY) begin
      if (UP) begin
        if (r_mode != FIRST) w_mode_nxt = mode_t'(r_mode - 3'd1);
      end else if (DOWN && r_mode != LAST) begin
        w_mode_nxt = mode_t'(r_mode + 3'd1);
      end
    end
  end

  assign w_scan_entry = (w_mode_nxt == SCAN) && (r_mode != SCAN);
  assign w_fill_start = (r_fst == IDLE) && (r_mode == FILL) && ACT;

  always_comb begin
    w_fst_nxt = r_fst;
    unique case (r_fst)
      IDLE:    if (w_fill_start) w_fst_nxt = RUN;
      RUN:     if (r_i == AW'(DEPTH-1)) w_fst_nxt = DONE;
      DONE:    w_fst_nxt = IDLE;
      default: w_fst_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_mode      <= MEM;
      r_fst       <= IDLE;
      r_mem_bit   <= 1'b0;
      r_reg       <= '0;
      r_scan_addr <= '0;
      r_tick      <= '0;
      r_run       <= 1'b1;
      r_base      <= '0;
      r_i         <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      r_fst  <= w_fst_nxt;
      if (SET && r_mode == MEM) r_mem_bit <= SW[0];
      if (SET && r_mode == REG) r_reg <= w_data;
      if (w_scan_entry) begin
        r_scan_addr <= '0;
        r_tick      <= '0;
        r_run       <= 1'b1;
      end else if (r_mode == SCAN) begin
        if (r_run) begin
          if (r_tick == TW'(SCAN_TICKS-1)) begin
            r_tick      <= '0;
            r_scan_addr <= r_scan_addr + 1'b1;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        if (ACT) r_run <= !r_run;
      end
      if (w_fill_start) begin
        r_base <= w_data;
        r_i    <= '0;
      end else if (BUSY) begin
        r_i <= r_i + 1'b1;
      end
    end
  end

  // writes are gated by reset so an aborted fill stops cleanly
  assign w_we    = RESETN && (BUSY || (SET && r_mode == RAM));
  assign w_waddr = BUSY ? r_i : w_addr;
  assign w_wdata = BUSY ? r_base + WIDTH'(r_i) : w_data;
  assign w_raddr = (r_mode == SCAN) ? r_scan_addr : w_addr;

  jcs_sp_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    LED  = '0;
    WORD = W_MEM;
    unique case (r_mode)
      MEM: LED[0] = r_mem_bit;
      REG: begin
        WORD = W_REG;
        if (ENA) LED[WIDTH-1:0] = r_reg;
      end
      RAM: begin
        WORD = W_RAM;
        if (ENA) LED[WIDTH-1:0] = w_rdata;
      end
      SCAN: begin
        WORD            = r_run ? W_SCAN : W_PAUS;
        LED[8 +: AW]    = r_scan_addr;
        LED[WIDTH-1:0]  = w_rdata;
      end
      FILL: begin
        WORD = BUSY ? W_BSY : W_FILL;
        if (BUSY) LED[AW-1:0] = r_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jcs_mem_console.sv
// Directed + randomized bench for jcs_mem_console with a
// behavioural RAM/scan model kept in plain arrays and counters.
module tb_jcs_mem_console;

  logic        CLK = 1'b0;
  logic        RESETN, UP, DOWN, SET, ENA, ACT;
  logic [15:0] SW;
  logic [15:0] LED;
  logic [31:0] WORD;
  logic        BUSY;

  always #5 CLK = ~CLK;

  jcs_mem_console #(
    .WIDTH      (8),
    .AW         (4),
    .SCAN_TICKS (4)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .SW     (SW),
    .UP     (UP),
    .DOWN   (DOWN),
    .SET    (SET),
    .ENA    (ENA),
    .ACT    (ACT),
    .LED    (LED),
    .WORD   (WORD),
    .BUSY   (BUSY)
  );

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] m_ram [16];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input int k);
    case (k)
      0: UP   = 1'b1;
      1: DOWN = 1'b1;
      2: SET  = 1'b1;
      default: ACT = 1'b1;
    endcase
    step();
    UP = 1'b0; DOWN = 1'b0; SET = 1'b0; ACT = 1'b0;
  endtask

  task automatic rd_chk(input int a);
    SW[11:8] = 4'(a);
    step();
    chk("ram_rd", 32'(LED), {24'h0, m_ram[a]});
  endtask

  initial begin
    int         cnt, n, a, prev;
    logic       m_run, act;
    logic [7:0] d, old;

    RESETN = 1'b0; UP = 0; DOWN = 0; SET = 0; ENA = 0; ACT = 0;
    SW = 16'h0;
    step(); step();
    RESETN = 1'b1;
    chk("rst_led", 32'(LED), 32'h0);
    chk("rst_word", WORD, " mem");
    chk("rst_busy", 32'(BUSY), 32'h0);

    SW = 16'h0001; pulse(2);
    chk("mem_set1", 32'(LED), 32'h1);
    SW = 16'h0000; pulse(2);
    chk("mem_set0", 32'(LED), 32'h0);

    pulse(1);
    chk("reg_word", WORD, " reg");
    ENA = 1'b1;
    d = 8'($urandom);
    SW = {8'h0, d}; pulse(2);
    chk("reg_val", 32'(LED), {24'h0, d});
    ENA = 1'b0; step();
    chk("reg_ena0", 32'(LED), 32'h0);

    UP = 1'b1; DOWN = 1'b1; step(); UP = 1'b0; DOWN = 1'b0;
    chk("updown", WORD, " mem");
    pulse(0);
    chk("clamp_lo", WORD, " mem");
    pulse(1); pulse(1);
    chk("ram_word", WORD, " ram");

    ENA = 1'b1;
    SW = 16'h03A5; pulse(2);
    m_ram[3] = 8'hA5;
    step();
    chk("ram_a5", 32'(LED), 32'hA5);
    ENA = 1'b0; step();
    chk("ram_ena0", 32'(LED), 32'h0);
    ENA = 1'b1;

    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      SW = {4'h0, 4'(i), d};
      pulse(2);
      m_ram[i] = d;
    end
    for (int k = 0; k < 6; k++) rd_chk(int'($urandom_range(0, 15)));

    a = int'($urandom_range(0, 15));
    SW[11:8] = 4'(a); step();
    old = m_ram[a];
    d = old ^ 8'h5A;
    SW[7:0] = d; pulse(2);
    chk("rf_old", 32'(LED), {24'h0, old});
    step();
    chk("rf_new", 32'(LED), {24'h0, d});
    m_ram[a] = d;

    pulse(1); pulse(1);
    chk("fill_word", WORD, "fill");
    pulse(1);
    chk("clamp_hi", WORD, "fill");

    SW[7:0] = 8'hFE; pulse(3);
    chk("bsy_word", WORD, " bsy");
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 40) begin
      chk("fill_i", 32'(LED), 32'(cnt));
      if (cnt == 3) begin UP = 1'b1; ACT = 1'b1; end
      step();
      UP = 1'b0; ACT = 1'b0;
      cnt++;
    end
    chk("busy_len", 32'(cnt), 32'd16);
    chk("fill_done_word", WORD, "fill");
    chk("fill_done_led", 32'(LED), 32'h0);
    step();
    chk("fill_idle_busy", 32'(BUSY), 32'h0);
    for (int i = 0; i < 16; i++) m_ram[i] = 8'(8'hFE + i);

    pulse(0); pulse(0);
    chk("back_ram", WORD, " ram");
    rd_chk(0); rd_chk(1); rd_chk(2); rd_chk(15);
    chk("wrap_val", {24'h0, m_ram[2]}, 32'h00);

    ENA = 1'b0;
    pulse(1);
    chk("scan_word", WORD, "scan");
    chk("scan_entry", 32'(LED[15:8]), 32'h0);
    n = 0; m_run = 1'b1; prev = 0;
    for (int c = 0; c < 110; c++) begin
      act = (c == 70) || (c == 90);
      ACT = act; step(); ACT = 1'b0;
      if (m_run) n++;
      if (act) m_run = !m_run;
      a = (n / 4) % 16;
      chk("scan_addr", 32'(LED[15:8]), 32'(a));
      if (a == prev) chk("scan_data", 32'(LED[7:0]), {24'h0, m_ram[a]});
      chk("scan_word", WORD, m_run ? "scan" : "paus");
      prev = a;
    end

    pulse(1);
    SW[7:0] = 8'h30; pulse(3);
    cnt = 0;
    while (LED !== 16'd5 && cnt < 40) begin
      step();
      cnt++;
    end
    chk("abort_at5", 32'(LED), 32'h5);
    RESETN = 1'b0; step();
    chk("abort_busy", 32'(BUSY), 32'h0);
    chk("abort_led", 32'(LED), 32'h0);
    chk("abort_word", WORD, " mem");
    RESETN = 1'b1;
    for (int i = 0; i < 5; i++) m_ram[i] = 8'(8'h30 + i);

    pulse(1); pulse(1);
    ENA = 1'b1;
    for (int i = 0; i < 16; i++) rd_chk(i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
